// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants: active-low hex glyphs, blank pattern and
// the active-low one-hot anode helper.
package seven_seg_pkg;

  localparam int MAX_DIGITS = 16;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // g..a, active-low, entry n is the glyph for hex digit n
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [MAX_DIGITS-1:0] digit_onehot_n(input logic [3:0] index);
    return ~(MAX_DIGITS'(1) << index);
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Nibble + decimal point to active-low 8-bit segment pattern ([7] = DP).
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       point,
  output logic [7:0] segment
);

  assign segment = {~point, SEG_HEX[nibble]};

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode display driver with double-buffered image,
// per-digit blink, global PWM brightness and registered pin outputs.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_BITS   = 17,
  parameter int BRIGHT_BITS = 4,
  parameter int BLINK_BITS  = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_enable,
  input  logic [NUM_DIGITS-1:0]   load_point,
  input  logic [NUM_DIGITS-1:0]   load_blink,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              segment,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] data;
    logic [NUM_DIGITS-1:0]      enable;
    logic [NUM_DIGITS-1:0]      point;
    logic [NUM_DIGITS-1:0]      blink;
  } image_t;

  image_t                      shadow, active;
  logic                        pending;
  logic [SCAN_BITS-1:0]        presc;
  logic [IDX_W-1:0]            idx;
  logic [BLINK_BITS-1:0]       blink_cnt;
  logic [NUM_DIGITS-1:0][7:0]  seg_all;
  logic                        terminal, last_digit, frame_end;
  logic                        bright_on, lit;
  logic [BRIGHT_BITS-1:0]      duty;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
    seven_seg_decode u_dec (
      .nibble  (active.data[d]),
      .point   (active.point[d]),
      .segment (seg_all[d])
    );
  end

  assign terminal   = &presc;
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_end  = terminal & last_digit;
  assign load_ready = ~pending;

  // full-scale brightness is forced on so the top code means 100%, not 15/16
  assign duty      = presc[SCAN_BITS-1 -: BRIGHT_BITS];
  assign bright_on = (&brightness) | (duty < brightness);
  assign lit       = active.enable[idx] & bright_on
                   & ~(blink_cnt[BLINK_BITS-1] & active.blink[idx]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc     <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      presc     <= presc + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (terminal) idx <= last_digit ? '0 : idx + 1'b1;
    end
  end

  // pending blocks new transfers, so capture and commit never coincide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (load_valid && !pending) begin
      shadow  <= {load_data, load_enable, load_point, load_blink};
      pending <= 1'b1;
    end else if (frame_end && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode      <= '1;
      segment    <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      anode      <= lit ? NUM_DIGITS'(digit_onehot_n(4'(idx))) : '1;
      segment    <= lit ? seg_all[idx] : SEG_BLANK;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: 4-digit and 3-digit instances driven in
// lockstep and checked every cycle against a cycle-count based reference.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic [3:0]  load_enable = '0, load_point = '0, load_blink = '0;
  logic [3:0]  brightness = 4'hF;

  logic        ready1, tick1, ready2, tick2;
  logic [3:0]  anode1;
  logic [2:0]  anode2;
  logic [7:0]  seg1, seg2;

  int vec = 0;
  int bad = 0;
  int k = 0;
  int last_tick2 = -1;

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(4), .SCAN_BITS(4), .BRIGHT_BITS(4), .BLINK_BITS(6)) dut1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready1),
    .load_data(load_data), .load_enable(load_enable), .load_point(load_point),
    .load_blink(load_blink), .brightness(brightness), .anode(anode1),
    .segment(seg1), .frame_tick(tick1)
  );

  seven_seg_scan #(.NUM_DIGITS(3), .SCAN_BITS(4), .BRIGHT_BITS(4), .BLINK_BITS(6)) dut2 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready2),
    .load_data(load_data[11:0]), .load_enable(load_enable[2:0]), .load_point(load_point[2:0]),
    .load_blink(load_blink[2:0]), .brightness(brightness), .anode(anode2),
    .segment(seg2), .frame_tick(tick2)
  );

  logic [6:0] hex_tb [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [3:0] anode;
    logic [7:0] seg;
    logic       tick;
    logic       ready;
  } exp_t;

  typedef struct {
    bit          pend;
    logic [15:0] sd, ad;
    logic [3:0]  se, sp, sb, ae, ap, ab;
  } mst_t;

  exp_t q1[$], q2[$];
  mst_t m1, m2;

  // expected outputs after the next edge, from the state reached after kk edges
  function automatic exp_t predict(input mst_t m, input int n, input int kk, input logic [3:0] br);
    exp_t e;
    int   presc, idx;
    bit   lit;
    presc = kk % 16;
    idx   = (kk / 16) % n;
    lit   = m.ae[idx] && (br == 4'hF || presc < int'(br)) && !(((kk % 64) >= 32) && m.ab[idx]);
    e.anode = lit ? ~(4'b0001 << idx) : 4'hF;
    e.seg   = lit ? {~m.ap[idx], hex_tb[m.ad[idx*4 +: 4]]} : 8'hFF;
    e.tick  = (presc == 15) && (idx == n - 1);
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic mst_t advance(input mst_t m, input int n, input int kk);
    bit fe;
    fe = (kk % 16 == 15) && ((kk / 16) % n == n - 1);
    if (load_valid && !m.pend) begin
      m.sd = load_data; m.se = load_enable; m.sp = load_point; m.sb = load_blink;
      m.pend = 1'b1;
    end else if (fe && m.pend) begin
      m.ad = m.sd; m.ae = m.se; m.ap = m.sp; m.ab = m.sb;
      m.pend = 1'b0;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp_v);
    end
  endtask

  task automatic tick();
    exp_t e1, e2;
    e1 = predict(m1, 4, k, brightness);
    e2 = predict(m2, 3, k, brightness);
    m1 = advance(m1, 4, k);
    m2 = advance(m2, 3, k);
    e1.ready = !m1.pend;
    e2.ready = !m2.pend;
    q1.push_back(e1);
    q2.push_back(e2);
    @(posedge clk);
    #1;
    k++;
    e1 = q1.pop_front();
    e2 = q2.pop_front();
    chk("anode1", anode1, e1.anode);
    chk("seg1",   seg1,   e1.seg);
    chk("tick1",  tick1,  e1.tick);
    chk("ready1", ready1, e1.ready);
    chk("anode2", {1'b1, anode2}, e2.anode);
    chk("seg2",   seg2,   e2.seg);
    chk("tick2",  tick2,  e2.tick);
    chk("ready2", ready2, e2.ready);
    if (tick2) begin
      if (last_tick2 >= 0) chk("period2", k - last_tick2, 48);
      last_tick2 = k;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_k(input int t);
    int w = 0;
    while (k < t && w < 5000) begin tick(); w++; end
    chk("wait_k", k, t);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p, input logic [3:0] b);
    int w = 0;
    while (!ready1 && w < 200) begin tick(); w++; end
    chk("ready_wait", ready1, 1);
    load_valid = 1'b1; load_data = d; load_enable = e; load_point = p; load_blink = b;
    tick();
    load_valid = 1'b0;
    chk("ready_drop", ready1, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_anode1", anode1, 4'hF);
    chk("rst_seg1",   seg1,   8'hFF);
    chk("rst_tick1",  tick1,  0);
    chk("rst_ready1", ready1, 1);
    chk("rst_anode2", anode2, 3'h7);
    chk("rst_seg2",   seg2,   8'hFF);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    k = 0;
    last_tick2 = -1;
    m1 = '{default: '0};
    m2 = '{default: '0};
  endtask

  int cnt [4];
  int low_total;

  initial begin
    m1 = '{default: '0};
    m2 = '{default: '0};
    #12;
    check_reset_outputs();
    release_reset();
    run(3);

    // basic scan of 1234 with DP on digit 2
    load(16'h1234, 4'hF, 4'b0100, 4'b0000);
    wait_k(65);
    chk("dig0_anode", anode1, 4'b1110); chk("dig0_seg", seg1, 8'b10011001);
    wait_k(81);
    chk("dig1_anode", anode1, 4'b1101); chk("dig1_seg", seg1, 8'b10110000);
    wait_k(97);
    chk("dig2_anode", anode1, 4'b1011); chk("dig2_seg", seg1, 8'b00100100);
    wait_k(113);
    chk("dig3_anode", anode1, 4'b0111); chk("dig3_seg", seg1, 8'b11111001);

    // mid-frame load must not show until the frame boundary
    wait_k(140);
    load(16'hABCD, 4'hF, 4'b0000, 4'b0000);
    wait_k(150);
    chk("old_anode", anode1, 4'b1101); chk("old_seg", seg1, 8'b10110000);
    wait_k(192);
    chk("frame_tick", tick1, 1);
    wait_k(193);
    chk("new_anode", anode1, 4'b1110); chk("new_seg", seg1, 8'b10100001);

    // brightness 4: four lit cycles per digit slot over one frame
    brightness = 4'd4;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    repeat (64) begin
      tick();
      for (int i = 0; i < 4; i++) if (anode1[i] == 1'b0) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) chk("duty4", cnt[i], 4);
    brightness = 4'd0;
    low_total = 0;
    repeat (64) begin
      tick();
      if (anode1 != 4'hF) low_total++;
    end
    chk("duty0", low_total, 0);
    brightness = 4'hF;

    // blink on digit 0 only
    load(16'h5678, 4'hF, 4'b0000, 4'b0001);
    run(256);

    // transfer in the frame-end cycle: commit deferred a full frame
    begin
      int w = 0;
      while (!((k % 64) == 63 && ready1) && w < 500) begin tick(); w++; end
    end
    chk("align", k % 64, 63);
    load(16'h0F0F, 4'hF, 4'b1010, 4'b0000);
    run(32);
    chk("ready_hold", ready1, 0);
    run(64);
    chk("ready_back", ready1, 1);

    // reset with a load pending discards both shadow and active images
    load(16'h9999, 4'hF, 4'hF, 4'b0000);
    run(5);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    release_reset();
    run(140);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
